// File: rtl/instr_loader_encoder.sv
// Program loader: packs field-level instruction commands into 32-bit words and writes them
// to consecutive instruction-memory addresses, flagging illegal encodings and overflow.
module instr_loader_encoder #(
   parameter int unsigned ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_class,
   input  logic [5:0]        cmd_funct,
   input  logic [3:0]        cmd_cond,
   input  logic [3:0]        cmd_rn,
   input  logic [3:0]        cmd_rd,
   input  logic [23:0]       cmd_imm,
   input  logic              cmd_idxsel,
   input  logic              cmd_last,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              busy,
   output logic              done,
   output logic              err_illegal,
   output logic              err_overflow,
   output logic [ADDR_W:0]   count
);

   typedef enum logic [1:0] {StIdle, StLoad, StWrite, StDone} state_e;

   // Count value meaning every memory word has been written.
   localparam logic [ADDR_W:0] FullCnt = {1'b1, {ADDR_W{1'b0}}};

   state_e          state_q, state_d;
   logic [ADDR_W:0] cnt_q, cnt_d, cnt_inc;
   logic [31:0]     wdata_q, wdata_d, enc_word;
   logic            last_q, last_d;
   logic            ill_q, ill_d;
   logic            ovf_q, ovf_d;
   logic            enc_legal;
   logic            hs;

   assign hs      = cmd_valid & cmd_ready;
   assign cnt_inc = cnt_q + 1'b1;

   // Encoder is the inverse of the control-unit field decode.
   always_comb begin
      enc_word  = '0;
      enc_legal = 1'b1;
      if (cmd_class == 2'b10) begin
         enc_word = {cmd_cond, 2'b10, 1'b1, cmd_funct[4], cmd_imm};
      end else begin
         enc_word = {cmd_cond, cmd_class, cmd_funct, cmd_rn, cmd_rd, cmd_imm[11:0]};
         if (cmd_class == 2'b11) enc_word[11] = cmd_idxsel;
      end
      case (cmd_class)
         2'b00: begin
            case (cmd_funct[4:1])
               4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1101: enc_legal = 1'b1;
               4'b1010: enc_legal = cmd_funct[0];  // CMP must set flags
               default: enc_legal = 1'b0;
            endcase
         end
         2'b11:   enc_legal = (cmd_funct[4:1] >= 4'd1) && (cmd_funct[4:1] <= 4'd4);
         default: enc_legal = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         wdata_q <= '0;
         last_q  <= 1'b0;
         ill_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wdata_q <= wdata_d;
         last_q  <= last_d;
         ill_q   <= ill_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wdata_d = wdata_q;
      last_d  = last_q;
      ill_d   = ill_q;
      ovf_d   = ovf_q;
      case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StLoad;
               cnt_d   = '0;
               ill_d   = 1'b0;
               ovf_d   = 1'b0;
            end
         end
         StLoad: begin
            if (hs) begin
               wdata_d = enc_word;
               last_d  = cmd_last;
               if (enc_legal) begin
                  state_d = StWrite;
               end else begin
                  ill_d = 1'b1;
                  if (cmd_last) state_d = StDone;
               end
            end
         end
         StWrite: begin
            cnt_d = cnt_inc;
            if (last_q) begin
               state_d = StDone;
            end else if (cnt_inc == FullCnt) begin
               state_d = StDone;
               ovf_d   = 1'b1;
            end else begin
               state_d = StLoad;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      cmd_ready    = (state_q == StLoad);
      mem_we       = (state_q == StWrite);
      busy         = (state_q != StIdle);
      done         = (state_q == StDone);
      mem_addr     = cnt_q[ADDR_W-1:0];
      mem_wdata    = wdata_q;
      count        = cnt_q;
      err_illegal  = ill_q;
      err_overflow = ovf_q;
   end

endmodule

// File: tb/tb_instr_loader_encoder.sv
// Directed bench for instr_loader_encoder: a full-size instance plus an ADDR_W=2 instance
// used for the overflow scenario.
module tb_instr_loader_encoder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, cmd_valid, cmd_ready;
   logic [1:0]  cmd_class;
   logic [5:0]  cmd_funct;
   logic [3:0]  cmd_cond, cmd_rn, cmd_rd;
   logic [23:0] cmd_imm;
   logic        cmd_idxsel, cmd_last;
   logic        mem_we, busy, done, err_illegal, err_overflow;
   logic [7:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [8:0]  count;

   logic        start2, cmd_valid2, cmd_ready2;
   logic        mem_we2, busy2, done2, err_illegal2, err_overflow2;
   logic [1:0]  mem_addr2;
   logic [31:0] mem_wdata2;
   logic [2:0]  count2;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   instr_loader_encoder #(.ADDR_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_class(cmd_class), .cmd_funct(cmd_funct), .cmd_cond(cmd_cond), .cmd_rn(cmd_rn),
      .cmd_rd(cmd_rd), .cmd_imm(cmd_imm), .cmd_idxsel(cmd_idxsel), .cmd_last(cmd_last),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .done(done),
      .err_illegal(err_illegal), .err_overflow(err_overflow), .count(count)
   );

   instr_loader_encoder #(.ADDR_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
      .cmd_class(cmd_class), .cmd_funct(cmd_funct), .cmd_cond(cmd_cond), .cmd_rn(cmd_rn),
      .cmd_rd(cmd_rd), .cmd_imm(cmd_imm), .cmd_idxsel(cmd_idxsel), .cmd_last(cmd_last),
      .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .busy(busy2),
      .done(done2), .err_illegal(err_illegal2), .err_overflow(err_overflow2), .count(count2)
   );

   // Write/done logs, sampled on the falling edge.
   logic [7:0]  wr_addr [0:63];
   logic [31:0] wr_data [0:63];
   int          wr_n = 0, done_n = 0;
   logic [8:0]  done_cnt;
   logic        done_ill, done_ovf;
   logic [1:0]  wr2_addr [0:63];
   int          wr2_n = 0, done2_n = 0;
   logic [2:0]  done2_cnt;
   logic        done2_ovf;

   always @(negedge clk) begin
      if (mem_we && wr_n < 64) begin
         wr_addr[wr_n] = mem_addr;
         wr_data[wr_n] = mem_wdata;
         wr_n = wr_n + 1;
      end
      if (done) begin
         done_n   = done_n + 1;
         done_cnt = count;
         done_ill = err_illegal;
         done_ovf = err_overflow;
      end
      if (mem_we2 && wr2_n < 64) begin
         wr2_addr[wr2_n] = mem_addr2;
         wr2_n = wr2_n + 1;
      end
      if (done2) begin
         done2_n   = done2_n + 1;
         done2_cnt = count2;
         done2_ovf = err_overflow2;
      end
   end

   task automatic start_load();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_cmd(input logic [1:0] c, input logic [5:0] f, input logic [3:0] cond,
                           input logic [3:0] rn, input logic [3:0] rd, input logic [23:0] imm,
                           input logic idx, input logic last);
      int w = 0;
      cmd_class = c; cmd_funct = f; cmd_cond = cond; cmd_rn = rn; cmd_rd = rd;
      cmd_imm = imm; cmd_idxsel = idx; cmd_last = last; cmd_valid = 1'b1;
      while (!cmd_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      if (!cmd_ready) begin
         total++; bad++;
         $display("FAIL handshake_timeout got=%b want=1", cmd_ready);
      end
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input int d0);
      int w = 0;
      while (done_n <= d0 && w < 30) begin
         @(negedge clk);
         w++;
      end
      if (done_n <= d0) begin
         total++; bad++;
         $display("FAIL done_timeout got=%0d want>%0d", done_n, d0);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b want=0", cmd_ready); end
      total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_we got=%b want=0", mem_we); end
      total++; if (mem_addr !== 8'h0) begin bad++; $display("FAIL rst_addr got=%h want=0", mem_addr); end
      total++; if (mem_wdata !== 32'h0) begin bad++; $display("FAIL rst_wdata got=%h want=0", mem_wdata); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", done); end
      total++; if (err_illegal !== 1'b0) begin bad++; $display("FAIL rst_ill got=%b want=0", err_illegal); end
      total++; if (err_overflow !== 1'b0) begin bad++; $display("FAIL rst_ovf got=%b want=0", err_overflow); end
      total++; if (count !== 9'd0) begin bad++; $display("FAIL rst_count got=%0d want=0", count); end
      total++; if (busy2 !== 1'b0) begin bad++; $display("FAIL rst_busy2 got=%b want=0", busy2); end
   endtask

   task automatic test_add_timing();
      start_load();
      total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL add_ready got=%b want=1", cmd_ready); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL add_busy got=%b want=1", busy); end
      cmd_class = 2'b00; cmd_funct = 6'b101000; cmd_cond = 4'hE; cmd_rn = 4'd2; cmd_rd = 4'd1;
      cmd_imm = 24'd5; cmd_idxsel = 1'b0; cmd_last = 1'b1; cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL add_we got=%b want=1", mem_we); end
      total++; if (mem_addr !== 8'h0) begin bad++; $display("FAIL add_addr got=%h want=0", mem_addr); end
      total++; if (mem_wdata !== 32'hE2821005) begin bad++; $display("FAIL add_wdata got=%h want=e2821005", mem_wdata); end
      total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL add_ready_wr got=%b want=0", cmd_ready); end
      @(negedge clk);
      total++; if (done !== 1'b1) begin bad++; $display("FAIL add_done got=%b want=1", done); end
      total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL add_we_off got=%b want=0", mem_we); end
      total++; if (count !== 9'd1) begin bad++; $display("FAIL add_count got=%0d want=1", count); end
      @(negedge clk);
      total++; if (done !== 1'b0) begin bad++; $display("FAIL add_done_pulse got=%b want=0", done); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL add_idle got=%b want=0", busy); end
   endtask

   task automatic test_branch();
      int base = wr_n;
      int d0 = done_n;
      start_load();
      send_cmd(2'b10, 6'b010000, 4'hE, 4'd0, 4'd0, 24'h000010, 1'b0, 1'b1);
      wait_done(d0);
      total++; if (wr_n !== base + 1) begin bad++; $display("FAIL bl_nwr got=%0d want=%0d", wr_n, base + 1); end
      total++; if (wr_data[base] !== 32'hEB000010) begin bad++; $display("FAIL bl_word got=%h want=eb000010", wr_data[base]); end
      total++; if (wr_addr[base] !== 8'h0) begin bad++; $display("FAIL bl_addr got=%h want=0", wr_addr[base]); end
   endtask

   task automatic test_vector_dot();
      int base = wr_n;
      int d0 = done_n;
      start_load();
      send_cmd(2'b11, 6'b000010, 4'hE, 4'd3, 4'd4, 24'h000005, 1'b1, 1'b1);
      wait_done(d0);
      total++; if (wr_n !== base + 1) begin bad++; $display("FAIL dot_nwr got=%0d want=%0d", wr_n, base + 1); end
      total++; if (wr_data[base] !== 32'hEC234805) begin bad++; $display("FAIL dot_word got=%h want=ec234805", wr_data[base]); end
   endtask

   task automatic test_illegal_mid();
      int base = wr_n;
      int d0 = done_n;
      start_load();
      send_cmd(2'b00, 6'b101000, 4'hE, 4'd2, 4'd1, 24'd5, 1'b0, 1'b0);
      send_cmd(2'b00, 6'b001100, 4'hE, 4'd2, 4'd1, 24'd5, 1'b0, 1'b0);
      send_cmd(2'b10, 6'b010000, 4'hE, 4'd0, 4'd0, 24'h000010, 1'b0, 1'b1);
      wait_done(d0);
      total++; if (wr_n !== base + 2) begin bad++; $display("FAIL ill_nwr got=%0d want=%0d", wr_n, base + 2); end
      total++; if (wr_addr[base] !== 8'd0) begin bad++; $display("FAIL ill_addr0 got=%h want=0", wr_addr[base]); end
      total++; if (wr_addr[base+1] !== 8'd1) begin bad++; $display("FAIL ill_addr1 got=%h want=1", wr_addr[base+1]); end
      total++; if (wr_data[base+1] !== 32'hEB000010) begin bad++; $display("FAIL ill_word1 got=%h want=eb000010", wr_data[base+1]); end
      total++; if (done_cnt !== 9'd2) begin bad++; $display("FAIL ill_count got=%0d want=2", done_cnt); end
      total++; if (done_ill !== 1'b1) begin bad++; $display("FAIL ill_flag got=%b want=1", done_ill); end
      total++; if (done_ovf !== 1'b0) begin bad++; $display("FAIL ill_ovf got=%b want=0", done_ovf); end
   endtask

   task automatic test_illegal_last();
      int base = wr_n;
      int d0 = done_n;
      start_load();
      // CMP without the flag-setting bit is illegal.
      send_cmd(2'b00, 6'b010100, 4'hE, 4'd1, 4'd0, 24'd0, 1'b0, 1'b1);
      wait_done(d0);
      total++; if (wr_n !== base) begin bad++; $display("FAIL illast_nwr got=%0d want=%0d", wr_n, base); end
      total++; if (done_cnt !== 9'd0) begin bad++; $display("FAIL illast_count got=%0d want=0", done_cnt); end
      total++; if (done_ill !== 1'b1) begin bad++; $display("FAIL illast_flag got=%b want=1", done_ill); end
      total++; if (err_illegal !== 1'b1) begin bad++; $display("FAIL illast_sticky got=%b want=1", err_illegal); end
      d0 = done_n;
      start_load();
      total++; if (err_illegal !== 1'b0) begin bad++; $display("FAIL illast_clear got=%b want=0", err_illegal); end
      send_cmd(2'b01, 6'b011001, 4'hE, 4'd0, 4'd1, 24'd0, 1'b0, 1'b1);
      wait_done(d0);
   endtask

   task automatic test_overflow();
      int hs = 0;
      cmd_class = 2'b01; cmd_funct = 6'b011001; cmd_cond = 4'hE; cmd_rn = 4'd0; cmd_rd = 4'd1;
      cmd_imm = 24'd4; cmd_idxsel = 1'b0; cmd_last = 1'b0;
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      cmd_valid2 = 1'b1;
      for (int i = 0; i < 30; i++) begin
         if (cmd_ready2) hs++;
         @(negedge clk);
      end
      cmd_valid2 = 1'b0;
      total++; if (hs !== 4) begin bad++; $display("FAIL ovf_accepted got=%0d want=4", hs); end
      total++; if (wr2_n !== 4) begin bad++; $display("FAIL ovf_nwr got=%0d want=4", wr2_n); end
      for (int i = 0; i < 4; i++) begin
         total++;
         if (wr2_addr[i] !== 2'(i)) begin bad++; $display("FAIL ovf_addr%0d got=%0d want=%0d", i, wr2_addr[i], i); end
      end
      total++; if (done2_n !== 1) begin bad++; $display("FAIL ovf_done got=%0d want=1", done2_n); end
      total++; if (done2_ovf !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b want=1", done2_ovf); end
      total++; if (done2_cnt !== 3'd4) begin bad++; $display("FAIL ovf_count got=%0d want=4", done2_cnt); end
      total++; if (err_overflow2 !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b want=1", err_overflow2); end
      total++; if (busy2 !== 1'b0) begin bad++; $display("FAIL ovf_idle got=%b want=0", busy2); end
   endtask

   task automatic test_reset_mid_write();
      int base;
      int d0;
      start_load();
      send_cmd(2'b01, 6'b011001, 4'hE, 4'd0, 4'd1, 24'd0, 1'b0, 1'b0);
      @(negedge clk);
      send_cmd(2'b01, 6'b011001, 4'hE, 4'd0, 4'd2, 24'd4, 1'b0, 1'b0);
      total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL rmid_pre_we got=%b want=1", mem_we); end
      total++; if (mem_addr !== 8'd1) begin bad++; $display("FAIL rmid_pre_addr got=%0d want=1", mem_addr); end
      #2 rst_n = 1'b0;
      #1;
      total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rmid_we got=%b want=0", mem_we); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b want=0", busy); end
      total++; if (count !== 9'd0) begin bad++; $display("FAIL rmid_count got=%0d want=0", count); end
      total++; if (mem_addr !== 8'd0) begin bad++; $display("FAIL rmid_addr got=%0d want=0", mem_addr); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      base = wr_n;
      d0 = done_n;
      start_load();
      send_cmd(2'b00, 6'b101000, 4'hE, 4'd2, 4'd1, 24'd5, 1'b0, 1'b1);
      wait_done(d0);
      total++; if (wr_n !== base + 1) begin bad++; $display("FAIL rmid_nwr got=%0d want=%0d", wr_n, base + 1); end
      total++; if (wr_addr[base] !== 8'd0) begin bad++; $display("FAIL rmid_restart_addr got=%0d want=0", wr_addr[base]); end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout got=running want=finished");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; start2 = 1'b0; cmd_valid = 1'b0; cmd_valid2 = 1'b0;
      cmd_class = '0; cmd_funct = '0; cmd_cond = '0; cmd_rn = '0; cmd_rd = '0;
      cmd_imm = '0; cmd_idxsel = 1'b0; cmd_last = 1'b0;
      repeat (2) @(negedge clk);
      test_reset();
      rst_n = 1'b1;
      @(negedge clk);
      test_add_timing();
      test_branch();
      test_vector_dot();
      test_illegal_mid();
      test_illegal_last();
      test_overflow();
      test_reset_mid_write();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
